// File: rtl/fetch_seq_pkg.sv
// Shared types and default sizes for the fetch sequencer.
//   seq_state_t : sequencer FSM state encoding (IDLE / RUN / DONE)
//   *_DEF       : default widths used by the top-level parameters
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int PC_BITS_DEF      = 12;
    localparam int LUT_IDX_BITS_DEF = 3;
    localparam int CNT_BITS_DEF     = 16;

endpackage

// File: rtl/fetch_sequencer_branch_lut.sv
// Branch target register file: 2**IDX_BITS entries of DATA_BITS each.
// Ports:
//   clk, rst_n        : clock, synchronous active-low clear of every entry
//   we, waddr, wdata  : synchronous write port (visible the cycle after)
//   raddr, rdata      : asynchronous read port; a same-cycle write is not
//                       seen by the read, so a branch gets the old value
module branch_lut #(
    parameter int IDX_BITS  = 3,
    parameter int DATA_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [IDX_BITS-1:0]  waddr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic [IDX_BITS-1:0]  raddr,
    output logic [DATA_BITS-1:0] rdata
);

    localparam int DEPTH = 2 ** IDX_BITS;

    logic [DATA_BITS-1:0] entry_q [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    entry_q[gi] <= '0;
                end else if (we && (waddr == IDX_BITS'(gi))) begin
                    entry_q[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata = entry_q[raddr];

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter controller for the instruction ROM.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : begin program at START_ADDR (from IDLE or DONE)
//   stall               : hold pc/count this cycle while running
//   halt                : current instruction is a halt
//   branch_en/branch_idx: taken branch, target read from the branch LUT
//   lut_we/waddr/wdata  : branch LUT config write port
//   pc                  : instruction memory address
//   fetch_valid         : pc addresses a live instruction (RUN)
//   done, overflow      : finished; overflow marks running off the ROM end
//   instr_count         : instructions retired since last start (saturating)
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int PC_BITS      = PC_BITS_DEF,
    parameter int LUT_IDX_BITS = LUT_IDX_BITS_DEF,
    parameter int START_ADDR   = 0,
    parameter int CNT_BITS     = CNT_BITS_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stall,
    input  logic                    halt,
    input  logic                    branch_en,
    input  logic [LUT_IDX_BITS-1:0] branch_idx,
    input  logic                    lut_we,
    input  logic [LUT_IDX_BITS-1:0] lut_waddr,
    input  logic [PC_BITS-1:0]      lut_wdata,
    output logic [PC_BITS-1:0]      pc,
    output logic                    fetch_valid,
    output logic                    done,
    output logic                    overflow,
    output logic [CNT_BITS-1:0]     instr_count
);

    localparam logic [PC_BITS-1:0] START_PC = PC_BITS'(START_ADDR);

    seq_state_t          state_q, state_d;
    logic [PC_BITS-1:0]  pc_q, pc_d;
    logic                done_q, done_d;
    logic                overflow_q, overflow_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    logic [PC_BITS-1:0]  lut_target;
    logic [CNT_BITS-1:0] cnt_inc;

    branch_lut #(
        .IDX_BITS  (LUT_IDX_BITS),
        .DATA_BITS (PC_BITS)
    ) u_lut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (lut_we),
        .waddr (lut_waddr),
        .wdata (lut_wdata),
        .raddr (branch_idx),
        .rdata (lut_target)
    );

    // Retired count sticks at all-ones instead of wrapping.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_BITS'(1);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        done_d     = done_q;
        overflow_d = overflow_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_PC;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (stall) begin
                    // freeze everything; halt/branch are re-presented later
                end else if (halt) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    overflow_d = 1'b0;
                    cnt_d      = cnt_inc;
                end else if (branch_en) begin
                    pc_d  = lut_target;
                    cnt_d = cnt_inc;
                end else if (pc_q == '1) begin
                    // last ROM word executed without halt: stop, do not wrap
                    state_d    = DONE;
                    done_d     = 1'b1;
                    overflow_d = 1'b1;
                end else begin
                    pc_d  = pc_q + PC_BITS'(1);
                    cnt_d = cnt_inc;
                end
            end
            DONE: begin
                if (start) begin
                    state_d    = RUN;
                    pc_d       = START_PC;
                    done_d     = 1'b0;
                    overflow_d = 1'b0;
                    cnt_d      = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pc          = pc_q;
    assign fetch_valid = (state_q == RUN);
    assign done        = done_q;
    assign overflow    = overflow_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a 12-bit-pc instance for the main
// sequence plus two 4-bit-pc instances for ROM-end overflow and counter
// saturation.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, stall, halt, branch_en, lut_we;
    logic [2:0]  branch_idx, lut_waddr;
    logic [11:0] lut_wdata;
    logic [11:0] pc;
    logic        fetch_valid, done, overflow;
    logic [15:0] instr_count;

    // small instances: own start, everything else idle
    logic        s_start;
    logic        s_zero;
    logic [2:0]  s_idx;
    logic [3:0]  s_wdata;
    logic [3:0]  a_pc, b_pc;
    logic        a_fv, a_done, a_ovf, b_fv, b_done, b_ovf;
    logic [15:0] a_cnt;
    logic [2:0]  b_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.PC_BITS(12), .LUT_IDX_BITS(3), .START_ADDR(0), .CNT_BITS(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
        .branch_en(branch_en), .branch_idx(branch_idx), .lut_we(lut_we),
        .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .pc(pc),
        .fetch_valid(fetch_valid), .done(done), .overflow(overflow),
        .instr_count(instr_count)
    );

    fetch_sequencer #(.PC_BITS(4), .LUT_IDX_BITS(3), .START_ADDR(0), .CNT_BITS(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(s_start), .stall(s_zero), .halt(s_zero),
        .branch_en(s_zero), .branch_idx(s_idx), .lut_we(s_zero),
        .lut_waddr(s_idx), .lut_wdata(s_wdata), .pc(a_pc),
        .fetch_valid(a_fv), .done(a_done), .overflow(a_ovf),
        .instr_count(a_cnt)
    );

    fetch_sequencer #(.PC_BITS(4), .LUT_IDX_BITS(3), .START_ADDR(0), .CNT_BITS(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(s_start), .stall(s_zero), .halt(s_zero),
        .branch_en(s_zero), .branch_idx(s_idx), .lut_we(s_zero),
        .lut_waddr(s_idx), .lut_wdata(s_wdata), .pc(b_pc),
        .fetch_valid(b_fv), .done(b_done), .overflow(b_ovf),
        .instr_count(b_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_main(input string tag, input logic [11:0] e_pc, input logic e_fv,
                            input logic e_done, input logic e_ovf, input logic [15:0] e_cnt);
        chk({tag, ".pc"}, 32'(pc), 32'(e_pc));
        chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(e_fv));
        chk({tag, ".done"}, 32'(done), 32'(e_done));
        chk({tag, ".overflow"}, 32'(overflow), 32'(e_ovf));
        chk({tag, ".count"}, 32'(instr_count), 32'(e_cnt));
        $display("step %-14s pc=%03h fv=%0b done=%0b ovf=%0b cnt=%0d",
                 tag, pc, fetch_valid, done, overflow, instr_count);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; halt = 1'b0; branch_en = 1'b0;
        lut_we = 1'b0; branch_idx = '0; lut_waddr = '0; lut_wdata = '0;
        s_start = 1'b0; s_zero = 1'b0; s_idx = '0; s_wdata = '0;

        // reset state
        tick(); tick();
        chk_main("reset", 12'h000, 1'b0, 1'b0, 1'b0, 16'd0);

        // 1: start at cycle 2, pc counts 0,1,2,3
        rst_n = 1'b1;
        tick();
        chk_main("idle_hold", 12'h000, 1'b0, 1'b0, 1'b0, 16'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_main("start", 12'h000, 1'b1, 1'b0, 1'b0, 16'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk_main("run", 12'(i), 1'b1, 1'b0, 1'b0, 16'(i));
        end

        // 2: LUT write then branch; write+branch same index uses old value
        lut_we = 1'b1; lut_waddr = 3'd5; lut_wdata = 12'h040;
        tick();
        lut_we = 1'b0;
        chk_main("lut_wr", 12'h004, 1'b1, 1'b0, 1'b0, 16'd4);
        branch_en = 1'b1; branch_idx = 3'd5;
        tick();
        chk_main("branch", 12'h040, 1'b1, 1'b0, 1'b0, 16'd5);
        lut_we = 1'b1; lut_wdata = 12'h080;
        tick();
        lut_we = 1'b0;
        chk_main("br_old_val", 12'h040, 1'b1, 1'b0, 1'b0, 16'd6);
        tick();
        chk_main("br_new_val", 12'h080, 1'b1, 1'b0, 1'b0, 16'd7);

        // 3: reach pc=7, stall 3 cycles with branch asserted
        lut_we = 1'b1; lut_waddr = 3'd1; lut_wdata = 12'h007;
        tick();
        lut_we = 1'b0;
        chk_main("br_self", 12'h080, 1'b1, 1'b0, 1'b0, 16'd8);
        branch_idx = 3'd1;
        tick();
        chk_main("to_7", 12'h007, 1'b1, 1'b0, 1'b0, 16'd9);
        stall = 1'b1; branch_idx = 3'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_main("stall", 12'h007, 1'b1, 1'b0, 1'b0, 16'd9);
        end
        stall = 1'b0; branch_en = 1'b0;
        tick();
        chk_main("unstall", 12'h008, 1'b1, 1'b0, 1'b0, 16'd10);
        tick();
        chk_main("to_9", 12'h009, 1'b1, 1'b0, 1'b0, 16'd11);

        // 4: halt+branch together -> DONE, halt wins
        halt = 1'b1; branch_en = 1'b1;
        tick();
        halt = 1'b0; branch_en = 1'b0;
        chk_main("halt", 12'h009, 1'b0, 1'b1, 1'b0, 16'd12);
        tick();
        chk_main("done_hold", 12'h009, 1'b0, 1'b1, 1'b0, 16'd12);
        start = 1'b1;
        tick();
        chk_main("restart", 12'h000, 1'b1, 1'b0, 1'b0, 16'd0);
        // start held high in RUN is ignored
        tick();
        chk_main("start_in_run", 12'h001, 1'b1, 1'b0, 1'b0, 16'd1);
        start = 1'b0;

        // 6: branch to 0x123, reset mid-RUN clears state and LUT
        lut_we = 1'b1; lut_waddr = 3'd2; lut_wdata = 12'h123;
        tick();
        lut_we = 1'b0;
        branch_en = 1'b1; branch_idx = 3'd2;
        tick();
        branch_en = 1'b0;
        chk_main("to_123", 12'h123, 1'b1, 1'b0, 1'b0, 16'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_main("mid_reset", 12'h000, 1'b0, 1'b0, 1'b0, 16'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        branch_en = 1'b1; branch_idx = 3'd2;
        tick();
        chk_main("lut2_clr", 12'h000, 1'b1, 1'b0, 1'b0, 16'd1);
        branch_idx = 3'd5;
        tick();
        branch_en = 1'b0;
        chk_main("lut5_clr", 12'h000, 1'b1, 1'b0, 1'b0, 16'd2);

        // 5: 4-bit pc free run off the end of ROM; 3-bit counter saturates
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("small.pc", 32'(a_pc), 32'(i));
        end
        chk("small.run_fv", 32'(a_fv), 32'd1);
        tick();
        chk("ovf.pc", 32'(a_pc), 32'd15);
        chk("ovf.done", 32'(a_done), 32'd1);
        chk("ovf.overflow", 32'(a_ovf), 32'd1);
        chk("ovf.fv", 32'(a_fv), 32'd0);
        chk("ovf.count", 32'(a_cnt), 32'd15);
        chk("sat.count", 32'(b_cnt), 32'd7);
        chk("sat.overflow", 32'(b_ovf), 32'd1);
        $display("step overflow       pc=%0h done=%0b ovf=%0b cnt=%0d sat_cnt=%0d",
                 a_pc, a_done, a_ovf, a_cnt, b_cnt);
        tick();
        chk("ovf_hold.pc", 32'(a_pc), 32'd15);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        chk("ovf_restart.pc", 32'(a_pc), 32'd0);
        chk("ovf_restart.overflow", 32'(a_ovf), 32'd0);
        chk("ovf_restart.done", 32'(a_done), 32'd0);
        $display("step ovf_restart    pc=%0h done=%0b ovf=%0b", a_pc, a_done, a_ovf);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
